// File: rtl/dmem_responder.sv
// dmem_responder: target end of the MEM-stage load/store interface.
// A request is accepted over valid/ready. The block then spends WAIT_STATES
// wait cycles, performs a read or a byte-masked write, and holds the
// response until the MEM stage takes it.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag out-of-range
// addresses with rsp_err. When it is undefined, addresses wrap modulo DEPTH.
module dmem_responder #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef logic [DEPTH-1:0][31:0] mem_t;

  // Power-up contents: each word holds its own index.
  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  // Storage is not touched by rst_n.
  mem_t mem_q = mem_init();

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_fire;
  logic          acc_oob;
  logic [31:0]   acc_rdata;

  // Access operands: the live request port when accessing on the accept
  // edge (zero wait states), otherwise the latched request.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_be    = req_be;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx   = acc_addr[AW-1:0];
  assign acc_rdata = mem_q[acc_idx];
  assign acc_fire  = ((state_q == S_IDLE) && req_valid && req_ready_q && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == '0));

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_oob = (acc_addr >= 32'(DEPTH));
`else
  assign acc_oob = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:AW];
`endif

  // Byte-masked store. The write is gated by rst_n because the FSM sits in
  // IDLE during reset, and a zero-wait accept would otherwise still fire.
  always_ff @(posedge clk) begin
    if (rst_n && acc_fire && acc_we && !acc_oob) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (acc_be[k]) mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            be_q        <= req_be;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= (acc_we || acc_oob) ? '0 : acc_rdata;
              rsp_err_q   <= acc_oob;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (acc_we || acc_oob) ? '0 : acc_rdata;
            rsp_err_q   <= acc_oob;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances share a clock and reset:
// instance 0 uses WAIT_STATES=2 and instance 1 uses WAIT_STATES=0.
// Expected data comes from a word-array model plus the byte-enable rule.
// Expected timing comes from the accept-to-response cycle count.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rv, rrdy, we, rspv, rsprdy, err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  be [2];

  int unsigned     total = 0;
  int unsigned     bad   = 0;
  longint unsigned cyc   = 0;
  int unsigned     ws_tab [2];
  logic [31:0]     model [2][DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_ready(rrdy[0]), .req_we(we[0]), .req_addr(addr[0]),
    .req_be(be[0]), .req_wdata(wdata[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rsprdy[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_ready(rrdy[1]), .req_we(we[1]), .req_addr(addr[1]),
    .req_be(be[1]), .req_wdata(wdata[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rsprdy[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Applies the architectural effect of one access to the model.
  // Returns the expected response data and error flag.
  task automatic model_access(input int d, input bit w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] wd,
                              output logic [31:0] exp_rd, output bit exp_err);
    int unsigned idx;
    idx     = a % DEPTH;
    exp_err = out_of_range(a);
    exp_rd  = '0;
    if (w) begin
      if (!exp_err)
        for (int k = 0; k < 4; k++)
          if (b[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
    end else if (!exp_err) begin
      exp_rd = model[d][idx];
    end
  endtask

  // Runs one full transaction. Entered and left at a falling edge.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input int hold, output longint unsigned rsp_cyc);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    check("req_ready_idle", rrdy[d], 1);
    rv[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    rsprdy[d] = 1'($urandom_range(0, 1));
    model_access(d, w, a, b, wd, exp_rd, exp_err);
    @(negedge clk);
    rv[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; be[d] = 4'($urandom); wdata[d] = $urandom;
    n = 1;
    while (!rspv[d] && n < 40) begin
      check("req_ready_busy", rrdy[d], 0);
      rsprdy[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("latency", n, ws_tab[d] + 1);
    rsp_cyc = cyc;
    check("rsp_rdata", rdata[d], exp_rd);
    check("rsp_err", err[d], exp_err);
    for (int h = 0; h < hold; h++) begin
      rsprdy[d] = 1'b0;
      @(negedge clk);
      check("hold_valid", rspv[d], 1);
      check("hold_rdata", rdata[d], exp_rd);
      check("hold_ready", rrdy[d], 0);
    end
    rsprdy[d] = 1'b1;
    @(negedge clk);
    rsprdy[d] = 1'b0;
    check("rsp_drop", rspv[d], 0);
    check("back_idle", rrdy[d], 1);
  endtask

  // Reset of instance 0 during WAIT (store discarded) or RESP (store kept).
  task automatic reset_mid(input bit in_resp, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          n;
    rv[0] = 1'b1; we[0] = 1'b1; addr[0] = a; be[0] = 4'hF; wdata[0] = wd;
    @(negedge clk);
    rv[0] = 1'b0;
    if (in_resp) begin
      n = 0;
      while (!rspv[0] && n < 40) begin @(negedge clk); n++; end
      check("rst_resp_reached", rspv[0], 1);
      model_access(0, 1'b1, a, 4'hF, wd, exp_rd, exp_err);
    end
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", rrdy[0], 1);
    check("rst_rsp_valid", rspv[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_err", err[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint unsigned c0, c1;
    ws_tab[0] = 2;
    ws_tab[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) model[d][i] = 32'(i);
    rst_n = 1'b0;
    rv = '0; we = '0; rsprdy = '0;
    for (int d = 0; d < 2; d++) begin addr[d] = '0; be[d] = '0; wdata[d] = '0; end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", rrdy[d], 1);
      check("reset_rsp_valid", rspv[d], 0);
      check("reset_rdata", rdata[d], 0);
      check("reset_err", err[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Load with two wait states, store with partial enables, then read back.
    txn(0, 1'b0, 32'd5, 4'h0, 32'h0, 0, c0);
    txn(0, 1'b1, 32'd7, 4'b0011, 32'hAABBCCDD, 0, c0);
    txn(0, 1'b0, 32'd7, 4'h0, 32'h0, 4, c0);
    // A store with no enables is a no-op that still responds.
    txn(0, 1'b1, 32'd8, 4'b0000, 32'h12345678, 1, c0);
    txn(0, 1'b0, 32'd8, 4'h0, 32'h0, 0, c0);
    // Reset during WAIT loses the store; reset during RESP keeps it.
    reset_mid(1'b0, 32'd3, 32'hFFFFFFFF);
    txn(0, 1'b0, 32'd3, 4'h0, 32'h0, 0, c0);
    reset_mid(1'b1, 32'd9, 32'hCAFEF00D);
    txn(0, 1'b0, 32'd9, 4'h0, 32'h0, 0, c0);
    // An address past DEPTH either wraps or reports an error.
    txn(0, 1'b0, 32'd33, 4'h0, 32'h0, 0, c0);
    txn(0, 1'b1, 32'd34, 4'hF, 32'h5A5A5A5A, 0, c0);
    txn(0, 1'b0, 32'd2, 4'h0, 32'h0, 0, c0);
    // Zero wait states: back-to-back loads issue every 2 cycles.
    txn(1, 1'b0, 32'd0, 4'h0, 32'h0, 0, c0);
    txn(1, 1'b0, 32'd1, 4'h0, 32'h0, 0, c1);
    check("b2b_interval", 32'(c1 - c0), 2);

    // Randomized traffic on both instances.
    for (int t = 0; t < 80; t++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 39));
      txn(d, 1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(0, 3)), c0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
